// File: rtl/ir_fetch_loader_pkg.sv
// Shared constants and types for the instruction fetch/load front end.
package ir_fetch_loader_pkg;

   localparam int DATA_WIDTH_DEF    = 16;
   localparam int IR_ADDR_WIDTH_DEF = 8;
   localparam int OPCODE_WIDTH_DEF  = 4;
   localparam int STABLE_CYCLES_DEF = 2;
   localparam int CTRL_BUS_DEF      = 2 ** OPCODE_WIDTH_DEF;

   // Locally handled opcodes at the default opcode width: HALT is all ones,
   // JMP is all ones minus one.
   localparam logic [OPCODE_WIDTH_DEF-1:0] OP_HALT = '1;
   localparam logic [OPCODE_WIDTH_DEF-1:0] OP_JMP  = OP_HALT - 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } state_t;

endpackage

// File: rtl/ir_fetch_loader_stable_filter.sv
// Host word debounce: a {tag,word} pair is accepted once it has been sampled
// unchanged STABLE_CYCLES times in a row and its tag differs from the tag of
// the previously accepted word.
module stable_filter #(
   parameter int DATA_WIDTH    = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_tag,
   output logic                  accept,
   output logic [DATA_WIDTH-1:0] word
);

   // Entry 0 is the newest sample; the tag sits in the top bit.
   logic [DATA_WIDTH:0]       hist_reg [STABLE_CYCLES];
   logic                      last_tag_reg;
   logic [STABLE_CYCLES-2:0]  match;

   genvar gi;
   generate
      for (gi = 1; gi < STABLE_CYCLES; gi++) begin : g_match
         assign match[gi-1] = (hist_reg[gi] == hist_reg[0]);
      end
   endgenerate

   assign word   = hist_reg[0][DATA_WIDTH-1:0];
   assign accept = enable && (&match) && (hist_reg[0][DATA_WIDTH] != last_tag_reg);

   // Sample history shift and last-accepted-tag tracking; clear wipes both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STABLE_CYCLES; i++) hist_reg[i] <= '0;
         last_tag_reg <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < STABLE_CYCLES; i++) hist_reg[i] <= '0;
         last_tag_reg <= 1'b0;
      end else begin
         hist_reg[0] <= {data_tag, data_in};
         for (int i = 1; i < STABLE_CYCLES; i++) hist_reg[i] <= hist_reg[i-1];
         if (accept) last_tag_reg <= hist_reg[0][DATA_WIDTH];
      end
   end

endmodule

// File: rtl/ir_fetch_loader.sv
// Instruction front end: loads debounced host words into instruction memory,
// then fetches sequentially, decodes the opcode one-hot and handles JMP/HALT.
module ir_fetch_loader
   import ir_fetch_loader_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int IR_ADDR_WIDTH = IR_ADDR_WIDTH_DEF,
   parameter int OPCODE_WIDTH  = OPCODE_WIDTH_DEF,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CTRL_BUS      = 2 ** OPCODE_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     init_req,
   input  logic [IR_ADDR_WIDTH-1:0] load_len,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     data_tag,
   input  logic [DATA_WIDTH-1:0]    ir,
   input  logic                     stall,
   output logic [IR_ADDR_WIDTH-1:0] irp,
   output logic                     ir_re,
   output logic                     ir_we,
   output logic [DATA_WIDTH-1:0]    ir_wdata,
   output logic                     ir_valid,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic [CTRL_BUS-1:0]      ctrl_bus,
   output logic                     busy
);

   localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = '1;
   localparam logic [OPCODE_WIDTH-1:0] OPC_JMP  = OPC_HALT - 1'b1;

   state_t                   state_reg, state_next;
   logic [IR_ADDR_WIDTH-1:0] irp_reg, irp_next;
   logic [IR_ADDR_WIDTH:0]   len_reg, len_next;
   logic [IR_ADDR_WIDTH:0]   cnt_reg, cnt_next;
   logic                     fetch_valid_reg, fetch_valid_next;
   logic                     ir_valid_reg, ir_valid_next;
   logic [DATA_WIDTH-1:0]    ir_word_reg, ir_word_next;

   logic                     accept;
   logic [DATA_WIDTH-1:0]    filt_word;
   logic [OPCODE_WIDTH-1:0]  ir_op;
   logic [OPCODE_WIDTH-1:0]  cur_op;

   assign ir_op  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
   assign cur_op = ir_word_reg[DATA_WIDTH-1 -: OPCODE_WIDTH];

   stable_filter #(
      .DATA_WIDTH    (DATA_WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (init_req),
      .enable   ((state_reg == ST_LOAD) && !init_req),
      .data_in  (data_in),
      .data_tag (data_tag),
      .accept   (accept),
      .word     (filt_word)
   );

   assign irp      = irp_reg;
   assign ir_re    = (state_reg == ST_RUN) && !stall;
   assign ir_we    = accept;
   assign ir_wdata = accept ? filt_word : '0;
   assign ir_valid = ir_valid_reg;
   assign busy     = (state_reg == ST_LOAD);
   assign data_out = {{OPCODE_WIDTH{1'b0}}, ir_word_reg[DATA_WIDTH-OPCODE_WIDTH-1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < CTRL_BUS; gi++) begin : g_decode
         assign ctrl_bus[gi] = ir_valid_reg && (cur_op == OPCODE_WIDTH'(gi));
      end
   endgenerate

   // Next-state and datapath update; init_req overrides everything else.
   always_comb begin
      state_next       = state_reg;
      irp_next         = irp_reg;
      len_next         = len_reg;
      cnt_next         = cnt_reg;
      fetch_valid_next = fetch_valid_reg;
      ir_valid_next    = ir_valid_reg;
      ir_word_next     = ir_word_reg;
      if (init_req) begin
         state_next       = ST_LOAD;
         irp_next         = '0;
         // A zero length means a full memory: the extra top bit encodes it.
         len_next         = {(load_len == '0), load_len};
         cnt_next         = '0;
         fetch_valid_next = 1'b0;
         ir_valid_next    = 1'b0;
      end else begin
         case (state_reg)
            ST_LOAD: begin
               if (accept) begin
                  cnt_next = cnt_reg + 1'b1;
                  if ((cnt_reg + 1'b1) == len_reg) begin
                     state_next       = ST_RUN;
                     irp_next         = '0;
                     fetch_valid_next = 1'b0;
                  end else begin
                     irp_next = irp_reg + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  irp_next         = irp_reg + 1'b1;
                  fetch_valid_next = 1'b1;
                  ir_valid_next    = fetch_valid_reg;
                  if (fetch_valid_reg) begin
                     ir_word_next = ir;
                     if (ir_op == OPC_JMP) begin
                        // The read issued this cycle is stale: drop it.
                        irp_next         = ir[IR_ADDR_WIDTH-1:0];
                        fetch_valid_next = 1'b0;
                     end else if (ir_op == OPC_HALT) begin
                        state_next       = ST_HALT;
                        fetch_valid_next = 1'b0;
                     end
                  end
               end
            end
            ST_HALT: ir_valid_next = 1'b0;
            default: ;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         irp_reg         <= '0;
         len_reg         <= '0;
         cnt_reg         <= '0;
         fetch_valid_reg <= 1'b0;
         ir_valid_reg    <= 1'b0;
         ir_word_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         irp_reg         <= irp_next;
         len_reg         <= len_next;
         cnt_reg         <= cnt_next;
         fetch_valid_reg <= fetch_valid_next;
         ir_valid_reg    <= ir_valid_next;
         ir_word_reg     <= ir_word_next;
      end
   end

endmodule

// File: tb/tb_ir_fetch_loader.sv
// Randomised bench for ir_fetch_loader: host-side loading with noise and
// glitches, then program execution compared against an instruction-level
// model of the fetch stream.
module tb_ir_fetch_loader;
   import ir_fetch_loader_pkg::*;

   localparam int DW = DATA_WIDTH_DEF;
   localparam int AW = IR_ADDR_WIDTH_DEF;
   localparam int OW = OPCODE_WIDTH_DEF;
   localparam int SC = STABLE_CYCLES_DEF;
   localparam int CB = CTRL_BUS_DEF;
   localparam int DEPTH = 2 ** AW;

   logic          clk, rst_n, init_req, data_tag, stall;
   logic [AW-1:0] load_len, irp;
   logic [DW-1:0] data_in, ir, ir_wdata, data_out;
   logic          ir_re, ir_we, ir_valid, busy;
   logic [CB-1:0] ctrl_bus;

   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] prog [DEPTH];
   int            seq_addr [300];
   int            seq_e    [300];
   int            nseq;
   logic          last_tag;
   int            n_checks, n_errors;

   ir_fetch_loader #(
      .DATA_WIDTH    (DW),
      .IR_ADDR_WIDTH (AW),
      .OPCODE_WIDTH  (OW),
      .STABLE_CYCLES (SC),
      .CTRL_BUS      (CB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_req (init_req),
      .load_len (load_len),
      .data_in  (data_in),
      .data_tag (data_tag),
      .ir       (ir),
      .stall    (stall),
      .irp      (irp),
      .ir_re    (ir_re),
      .ir_we    (ir_we),
      .ir_wdata (ir_wdata),
      .ir_valid (ir_valid),
      .data_out (data_out),
      .ctrl_bus (ctrl_bus),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: write port plus 1-cycle registered read that holds.
   always @(posedge clk) begin
      if (ir_we) mem[irp] <= ir_wdata;
      if (ir_re) ir <= mem[irp];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_irp"},   32'(irp),      32'd0);
      check({tag, "_re"},    32'(ir_re),    32'd0);
      check({tag, "_we"},    32'(ir_we),    32'd0);
      check({tag, "_wdata"}, 32'(ir_wdata), 32'd0);
      check({tag, "_valid"}, 32'(ir_valid), 32'd0);
      check({tag, "_dout"},  32'(data_out), 32'd0);
      check({tag, "_ctrl"},  32'(ctrl_bus), 32'd0);
      check({tag, "_busy"},  32'(busy),     32'd0);
   endtask

   // Random program of n words: forward jumps only, HALT as the last word.
   task automatic gen_random_prog(input int n);
      for (int i = 0; i < n - 1; i++) begin
         if ($urandom_range(0, 4) == 0 && i < n - 2)
            prog[i] = {OP_JMP, (DW-OW-AW)'($urandom), AW'($urandom_range(i + 1, n - 1))};
         else
            prog[i] = {OW'($urandom_range(0, 13)), (DW-OW)'($urandom)};
      end
      prog[n-1] = {OP_HALT, (DW-OW)'($urandom)};
   endtask

   // Executed instruction list: address of each instruction and the
   // non-stalled RUN step at which it is presented (first at step 2, one per
   // step, one extra step after every JMP).
   task automatic build_model();
      int pc, e;
      logic [DW-1:0] w;
      nseq = 0; pc = 0; e = 2;
      while (nseq < 300) begin
         seq_addr[nseq] = pc;
         seq_e[nseq]    = e;
         w = prog[pc];
         nseq++;
         if (w[DW-1 -: OW] == OP_HALT) break;
         if (w[DW-1 -: OW] == OP_JMP) begin
            pc = int'(w[AW-1:0]);
            e += 2;
         end else begin
            pc = (pc + 1) % DEPTH;
            e += 1;
         end
      end
   endtask

   // Load prog[0..n-1] through the host port; ends in the final accept cycle.
   task automatic load_program(input int n, input int noise_max, input int glitch_at);
      int nz, hold;
      load_len = AW'(n);
      init_req = 1'b1;
      tick();
      check("load_entry_busy", 32'(busy), 32'd1);
      check("load_entry_irp",  32'(irp),  32'd0);
      init_req = 1'b0;
      load_len = AW'($urandom);
      last_tag = 1'b0;
      for (int i = 0; i < n; i++) begin
         nz = $urandom_range(0, noise_max);
         repeat (nz) begin
            data_in = DW'($urandom); data_tag = last_tag;
            tick();
            check("noise_we", 32'(ir_we), 32'd0);
         end
         if (i == glitch_at) begin
            for (int g = 1; g <= 5; g++) begin
               data_in = prog[i] ^ DW'(g); data_tag = ~last_tag;
               tick();
               check("glitch_we", 32'(ir_we), 32'd0);
            end
         end
         data_in = prog[i]; data_tag = ~last_tag;
         repeat (SC - 1) begin
            tick();
            check("load_early_we", 32'(ir_we), 32'd0);
         end
         tick();
         check("load_we",    32'(ir_we),    32'd1);
         check("load_wdata", 32'(ir_wdata), 32'(prog[i]));
         check("load_irp",   32'(irp),      32'(i % DEPTH));
         check("load_busy",  32'(busy),     32'd1);
         $display("LOAD addr=%0d word=0x%04h tag=%0d", irp, ir_wdata, data_tag);
         last_tag = ~last_tag;
         if (i < n - 1) begin
            hold = $urandom_range(0, 2);
            repeat (hold) begin
               tick();
               check("hold_we",  32'(ir_we), 32'd0);
               check("hold_irp", 32'(irp),   32'((i + 1) % DEPTH));
            end
         end
      end
   endtask

   // Execute from the first RUN cycle until a few cycles past HALT.
   task automatic run_program(input int stall_pct, input int stall_at);
      int e, eh, cyc, limit, stall_left, vis, kk, exp_irp;
      bit used, s;
      logic [DW-1:0] w;
      logic [CB-1:0] oh;
      build_model();
      eh = seq_e[nseq-1];
      limit = 3 * eh + 40;
      e = 0; cyc = 0; used = 0; stall_left = 0;
      while (e <= eh + 3 && cyc < limit) begin
         tick();
         if (!used && e == stall_at) begin stall_left = 3; used = 1; end
         if (stall_left > 0) begin s = 1; stall_left--; end
         else s = ($urandom_range(0, 99) < stall_pct);
         stall = s;
         #1;
         vis = -1; kk = 0;
         for (int k = 0; k < nseq; k++) begin
            if (seq_e[k] == e) vis = k;
            if (seq_e[k] - 2 <= e) kk = k;
         end
         if (e >= eh) exp_irp = (seq_addr[nseq-1] + 2) % DEPTH;
         else         exp_irp = (seq_addr[kk] + e - seq_e[kk] + 2) % DEPTH;
         check("run_irp",   32'(irp),   32'(exp_irp));
         check("run_ir_re", 32'(ir_re), 32'((e < eh) && !s));
         check("run_busy",  32'(busy),  32'd0);
         check("run_we",    32'(ir_we), 32'd0);
         check("run_valid", 32'(ir_valid), 32'(vis >= 0));
         oh = '0;
         if (vis >= 0) begin
            w = prog[seq_addr[vis]];
            oh[w[DW-1 -: OW]] = 1'b1;
            check("run_dout", 32'(data_out), 32'(w[DW-OW-1:0]));
            if (!s) $display("RUN  step=%0d addr=%0d word=0x%04h", e, seq_addr[vis], w);
         end else if (e > eh) begin
            w = prog[seq_addr[nseq-1]];
            check("halt_dout", 32'(data_out), 32'(w[DW-OW-1:0]));
         end
         check("run_ctrl", 32'(ctrl_bus), 32'(oh));
         if (!s || e >= eh) e++;
         cyc++;
      end
      check("run_completed", 32'(e > eh + 3), 32'd1);
      stall = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; init_req = 1'b0; load_len = '0; data_in = '0;
      data_tag = 1'b0; stall = 1'b0;
      repeat (3) tick();
      check_quiet("in_reset");
      rst_n = 1'b1;
      repeat (10) begin
         data_in = DW'($urandom); data_tag = 1'($urandom);
         tick();
         check_quiet("idle");
      end

      // Identical words with toggled tags, glitchy host before the second.
      prog[0] = 16'h1234; prog[1] = 16'h1234; prog[2] = 16'hF000;
      load_program(3, 0, 1);
      run_program(0, -1);

      // JMP over two words, with a 3-cycle stall while JMP is presented.
      prog[0] = 16'h1005; prog[1] = 16'hE004; prog[2] = 16'h3333;
      prog[3] = 16'h4444; prog[4] = 16'h2007; prog[5] = 16'hF000;
      load_program(6, 0, -1);
      run_program(0, 3);

      // init_req arriving in an accept cycle suppresses the write.
      load_len = AW'(4); init_req = 1'b1;
      tick();
      init_req = 1'b0; data_in = 16'h0ABC; data_tag = 1'b1;
      repeat (SC) tick();
      check("clash_pre_we", 32'(ir_we), 32'd1);
      init_req = 1'b1;
      #1;
      check("clash_we",    32'(ir_we),    32'd0);
      check("clash_wdata", 32'(ir_wdata), 32'd0);
      tick();
      init_req = 1'b0;
      check("clash_irp",  32'(irp),  32'd0);
      check("clash_busy", 32'(busy), 32'd1);
      tick();
      check("clash_hist_we", 32'(ir_we), 32'd0);

      // Random programs with host noise and random stalls.
      for (int t = 0; t < 4; t++) begin
         int n;
         n = $urandom_range(3, 20);
         gen_random_prog(n);
         load_program(n, 2, -1);
         run_program(25, -1);
      end

      // load_len = 0 loads the full memory; fetch address wraps past the end.
      gen_random_prog(DEPTH);
      load_program(DEPTH, 0, -1);
      run_program(10, -1);

      // Asynchronous reset in the middle of a load.
      gen_random_prog(8);
      load_len = AW'(8); init_req = 1'b1;
      tick();
      init_req = 1'b0; data_in = prog[0]; data_tag = 1'b1;
      repeat (SC + 1) tick();
      check("midload_busy", 32'(busy), 32'd1);
      check("midload_irp",  32'(irp),  32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",  32'(busy),     32'd0);
      check("arst_irp",   32'(irp),      32'd0);
      check("arst_valid", 32'(ir_valid), 32'd0);
      check("arst_dout",  32'(data_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_quiet("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ir_fetch_loader.md
# ir_fetch_loader

Parametrised instruction front end that sits between the host data port, the instruction memory and the execution datapath. In LOAD mode it filters host words: a word is accepted only when stable for a programmable number of samples and carrying a fresh toggle tag. Each accepted word is written to instruction memory at an auto-incrementing pointer. In RUN mode it fetches sequentially from that memory, registers the instruction word and decodes its opcode onto a one-hot control bus, with JMP and HALT handled locally.

## Interface
- DATA_WIDTH, 16, instruction/host word width
- IR_ADDR_WIDTH, 8, instruction memory address width
- OPCODE_WIDTH, 4, opcode field = word[DATA_WIDTH-1 -: OPCODE_WIDTH]
- STABLE_CYCLES, 2, consecutive equal samples required to accept a host word (≥2)
- CTRL_BUS, 2**OPCODE_WIDTH, one-hot decode width
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- init_req  in  1  level request to enter or restart LOAD; has priority in every state
- load_len  in  IR_ADDR_WIDTH  words to load, sampled on LOAD entry; 0 means 2**IR_ADDR_WIDTH
- data_in  in  DATA_WIDTH  host word
- data_tag  in  1  host toggle; a new word must carry the inverse of the last accepted tag
- ir  in  DATA_WIDTH  memory read data, 1-cycle latency, held while ir_re=0
- stall  in  1  freezes RUN pipeline
- irp  out  IR_ADDR_WIDTH  memory address (write address in LOAD, fetch address in RUN)
- ir_re  out  1  read enable = (state==RUN) & !stall
- ir_we  out  1  one-cycle write strobe in LOAD
- ir_wdata  out  DATA_WIDTH  accepted word
- ir_valid  out  1  reg_ir holds a live instruction
- data_out  out  DATA_WIDTH  zero-extended immediate = reg_ir low DATA_WIDTH-OPCODE_WIDTH bits
- ctrl_bus  out  CTRL_BUS  one-hot of reg_ir opcode when ir_valid, else 0
- busy  out  1  state==LOAD

## Operation
- States: IDLE (reset), LOAD, RUN, HALT.
- Transitions:
  - init_req=1 in any state → LOAD: irp←0, length latched, filter history cleared, last_tag←0.
  - LOAD, final word written → RUN: irp←0, fetch_valid←0.
  - RUN, HALT (opcode all ones) captured → HALT.
  - HALT, IDLE: exit only via init_req.
- Filter: shift register of the last STABLE_CYCLES {data_tag,data_in} samples. Accept when all entries are equal and tag≠last_tag. On accept: ir_we=1, ir_wdata=word, write at current irp, last_tag←tag. irp increments on the following edge. Identical consecutive program words are legal because of the tag.
- RUN fetch: each non-stalled cycle issues irp and increments it (wraps modulo 2**IR_ADDR_WIDTH). fetch_valid marks that the previous cycle issued a read that is still wanted. On a non-stalled edge with fetch_valid=1: reg_ir←ir, ir_valid←1; otherwise ir_valid←0.
- JMP (opcode all ones minus 1): on the capture edge, irp←immediate[IR_ADDR_WIDTH-1:0] and fetch_valid←0. The in-flight read is discarded, giving exactly one bubble.
- HALT: the HALT word is presented for one cycle with ir_valid=1. ir_valid is then 0 and irp holds.
- stall=1: irp, reg_ir, ir_valid, fetch_valid and state all hold. ctrl_bus and data_out stay stable.

## Timing
- Reset: all outputs 0, state IDLE, reg_ir 0, filter history 0, last_tag 0.
- Host word accept latency: STABLE_CYCLES edges after the word and tag first appear. ir_we is asserted combinationally in the cycle the filter is full and matching.
- RUN start: irp=0 issued in the first RUN cycle. The first ir_valid appears 2 cycles after entering RUN.
- Steady state: one instruction per cycle. JMP costs 1 bubble. irp wraps from max to 0.
- init_req simultaneous with accept or JMP: init_req wins; no write, no jump.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE; memory contents are not touched by this block.

## Structure
- Shared package/header: DATA_WIDTH, IR_ADDR_WIDTH, OPCODE_WIDTH, CTRL_BUS defaults, state encodings, OP_HALT, OP_JMP.
- Sub-module: `stable_filter` (parametrised STABLE_CYCLES sample history, tag compare, accept pulse).

## Test plan
- Reset, then idle 10 cycles → all outputs 0, busy=0.
- Load 3 words with load_len=3, each held 2 cycles: 0x1234 tag1, 0x1234 tag0, 0xF000 tag1 → three ir_we pulses at irp 0,1,2 with matching ir_wdata. Enters RUN.
- Glitchy host: data changes every cycle for 5 cycles → no ir_we.
- RUN program {0x1005, 0xE004, x, x, 0x2007} → ctrl_bus bit1 with data_out=0x005, then bit14, one bubble, then bit2 with data_out=0x007.
- stall held 3 cycles mid-run → ctrl_bus and irp frozen, ir_re=0. Stream resumes with no lost or duplicated instruction.
- HALT captured → ir_valid 1 cycle then 0, irp holds. init_req then pulses busy=1 and irp=0. Assert rst_n=0 mid-LOAD → IDLE at once.
